// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Round-robin arbiter in front of one shared binary-to-BCD converter.
//   In IDLE it grants one of three level requesters, captures that
//   requester's 10-bit value (clamped to 999), and pulses conv_start. It
//   then waits CONV_CYCLES cycles, latches the converter digits and
//   publishes them with a one-cycle result_valid.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   req[2:0]              level requests, bit i = requester i
//   value0/1/2[9:0]       binary value of each requester
//   ack[2:0]              one-hot pulse, granted requester's value captured
//   busy                  high in every state except IDLE
//   conv_start            one-cycle start pulse to the converter
//   conv_data[9:0]        captured, clamped value sent to the converter
//   conv_d1/d10/d100      converter digit outputs
//   result_valid          one-cycle pulse, result outputs valid
//   result_id[1:0]        requester that owns the result
//   d1/d10/d100           latched BCD digits
//   result_sat            captured value exceeded 999
module bcd_conv_arbiter #(
  parameter int unsigned CONV_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [9:0] value0,
  input  logic [9:0] value1,
  input  logic [9:0] value2,
  output logic [2:0] ack,
  output logic       busy,
  output logic       conv_start,
  output logic [9:0] conv_data,
  input  logic [3:0] conv_d1,
  input  logic [3:0] conv_d10,
  input  logic [3:0] conv_d100,
  output logic       result_valid,
  output logic [1:0] result_id,
  output logic [3:0] d1,
  output logic [3:0] d10,
  output logic [3:0] d100,
  output logic       result_sat
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic       sat_q, sat_d;
  logic [2:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       conv_start_q, conv_start_d;
  logic [9:0] conv_data_q, conv_data_d;
  logic       result_valid_q, result_valid_d;
  logic [1:0] result_id_q, result_id_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d10_q, d10_d;
  logic [3:0] d100_q, d100_d;
  logic       result_sat_q, result_sat_d;

  // Round-robin pick: scan upward from rr_ptr, wrapping 2 -> 0.
  logic        found;
  logic [1:0]  pick;
  logic [9:0]  sel_val;
  logic        over;
  int unsigned slot;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    slot  = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      slot = 32'(rr_ptr_q) + k;
      if (slot >= 3) slot = slot - 3;
      if (!found && req[slot[1:0]]) begin
        found = 1'b1;
        pick  = slot[1:0];
      end
    end
    case (pick)
      2'd0:    sel_val = value0;
      2'd1:    sel_val = value1;
      default: sel_val = value2;
    endcase
    over = (sel_val > 10'd999);
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    sat_d          = sat_q;
    ack_d          = '0;
    busy_d         = busy_q;
    conv_start_d   = 1'b0;
    conv_data_d    = conv_data_q;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;
    d1_d           = d1_q;
    d10_d          = d10_q;
    d100_d         = d100_q;
    result_sat_d   = result_sat_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = START;
          grant_d      = pick;
          ack_d        = 3'(3'b001 << pick);
          conv_start_d = 1'b1;
          conv_data_d  = over ? 10'd999 : sel_val;
          sat_d        = over;
          busy_d       = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = 8'(CONV_CYCLES);
      end
      WAIT: begin
        if (cnt_q == 8'd1) begin
          state_d        = DONE;
          cnt_d          = '0;
          d1_d           = conv_d1;
          d10_d          = conv_d10;
          d100_d         = conv_d100;
          result_valid_d = 1'b1;
          result_id_d    = grant_q;
          result_sat_d   = sat_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        rr_ptr_d = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      grant_q        <= '0;
      sat_q          <= 1'b0;
      ack_q          <= '0;
      busy_q         <= 1'b0;
      conv_start_q   <= 1'b0;
      conv_data_q    <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      d1_q           <= '0;
      d10_q          <= '0;
      d100_q         <= '0;
      result_sat_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      sat_q          <= sat_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      conv_start_q   <= conv_start_d;
      conv_data_q    <= conv_data_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      d1_q           <= d1_d;
      d10_q          <= d10_d;
      d100_q         <= d100_d;
      result_sat_q   <= result_sat_d;
    end
  end

  assign ack          = ack_q;
  assign busy         = busy_q;
  assign conv_start   = conv_start_q;
  assign conv_data    = conv_data_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
  assign d1           = d1_q;
  assign d10          = d10_q;
  assign d100         = d100_q;
  assign result_sat   = result_sat_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter whose
// digits are only valid during the last WAIT cycle of each conversion.
module tb_bcd_conv_arbiter;

  localparam int C = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [9:0] value0, value1, value2;
  logic [2:0] ack;
  logic       busy, conv_start, result_valid, result_sat;
  logic [9:0] conv_data;
  logic [3:0] conv_d1, conv_d10, conv_d100;
  logic [1:0] result_id;
  logic [3:0] d1, d10, d100;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mcnt;

  bcd_conv_arbiter #(.CONV_CYCLES(C)) dut (
    .clock(clock), .reset(reset), .req(req),
    .value0(value0), .value1(value1), .value2(value2),
    .ack(ack), .busy(busy), .conv_start(conv_start), .conv_data(conv_data),
    .conv_d1(conv_d1), .conv_d10(conv_d10), .conv_d100(conv_d100),
    .result_valid(result_valid), .result_id(result_id),
    .d1(d1), .d10(d10), .d100(d100), .result_sat(result_sat)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Converter model: digits are valid only in the C-th cycle after conv_start.
  always @(posedge clock) begin
    if (reset)                         mcnt <= 0;
    else if (conv_start)               mcnt <= 1;
    else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
  end

  always_comb begin
    conv_d1   = 4'hF;
    conv_d10  = 4'hF;
    conv_d100 = 4'hF;
    if (mcnt == C) begin
      conv_d100 = 4'(conv_data / 100);
      conv_d10  = 4'((conv_data / 10) % 10);
      conv_d1   = 4'(conv_data % 10);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an ack, then checks the START-cycle outputs.
  task automatic expect_ack(input string tag, input logic [2:0] exp_ack,
                            input logic [9:0] exp_data, output int acyc);
    int n = 0;
    while (ack === 3'b000 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ack_timeout"}, 32'(n < 200), 32'd1);
    acyc = cyc;
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_conv_start"}, 32'(conv_start), 32'd1);
    chk({tag, "_conv_data"}, 32'(conv_data), 32'(exp_data));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Called at the negedge of cycle A + pre; ends at the negedge of A+C+2.
  task automatic expect_result(input string tag, input int pre, input logic [1:0] id,
                               input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] o, input logic sat);
    repeat (C - pre) @(negedge clock);
    chk({tag, "_rv_early"}, 32'(result_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    chk({tag, "_id"}, 32'(result_id), 32'(id));
    chk({tag, "_d100"}, 32'(d100), 32'(h));
    chk({tag, "_d10"}, 32'(d10), 32'(t));
    chk({tag, "_d1"}, 32'(d1), 32'(o));
    chk({tag, "_sat"}, 32'(result_sat), 32'(sat));
    @(negedge clock);
    chk({tag, "_rv_after"}, 32'(result_valid), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'({d100, d10, d1, result_id, result_sat}),
        32'({h, t, o, id, sat}));
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, "_outs"}, 32'({ack, busy, conv_start, result_valid, result_id, result_sat}), 32'd0);
    chk({tag, "_conv_data"}, 32'(conv_data), 32'd0);
    chk({tag, "_digits"}, 32'({d100, d10, d1}), 32'd0);
  endtask

  initial begin
    int a0, a1;
    reset = 1'b1; req = '0; value0 = '0; value1 = '0; value2 = '0;
    repeat (3) @(negedge clock);
    expect_all_zero("reset");
    reset = 1'b0;

    // Single request, requester 0
    value0 = 10'd437; req = 3'b001;
    @(negedge clock);
    expect_ack("single", 3'b001, 10'd437, a0);
    req = '0;
    expect_result("single", 0, 2'd0, 4'd4, 4'd3, 4'd7, 1'b0);

    // Clamp, requester 1 (rr_ptr now 1)
    value1 = 10'd1023; req = 3'b010;
    expect_ack("clamp", 3'b010, 10'd999, a0);
    req = '0;
    expect_result("clamp", 0, 2'd1, 4'd9, 4'd9, 4'd9, 1'b1);

    // Zero value, requester 2
    value2 = 10'd0; req = 3'b100;
    expect_ack("zero", 3'b100, 10'd0, a0);
    req = '0;
    expect_result("zero", 0, 2'd2, 4'd0, 4'd0, 4'd0, 1'b0);

    // Late request from 2 during requester 0's WAIT
    value0 = 10'd5; req = 3'b001;
    expect_ack("late0", 3'b001, 10'd5, a0);
    req = '0;
    repeat (3) @(negedge clock);
    value2 = 10'd123; req = 3'b100;
    @(negedge clock);
    chk("late_no_ack_in_wait", 32'({ack, conv_start}), 32'd0);
    expect_result("late0", 4, 2'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    expect_ack("late2", 3'b100, 10'd123, a1);
    chk("late_spacing", 32'(a1 - a0), 32'(C + 3));
    req = '0;
    expect_result("late2", 0, 2'd2, 4'd1, 4'd2, 4'd3, 1'b0);

    // Contention: req=111 held from reset
    reset = 1'b1;
    value0 = 10'd5; value1 = 10'd60; value2 = 10'd700; req = 3'b111;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    expect_ack("cont0", 3'b001, 10'd5, a0);
    expect_result("cont0", 0, 2'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    expect_ack("cont1", 3'b010, 10'd60, a1);
    chk("cont_spacing01", 32'(a1 - a0), 32'(C + 3));
    expect_result("cont1", 0, 2'd1, 4'd0, 4'd6, 4'd0, 1'b0);
    expect_ack("cont2", 3'b100, 10'd700, a0);
    chk("cont_spacing12", 32'(a0 - a1), 32'(C + 3));
    expect_result("cont2", 0, 2'd2, 4'd7, 4'd0, 4'd0, 1'b0);
    expect_ack("cont3", 3'b001, 10'd5, a1);
    chk("cont_spacing20", 32'(a1 - a0), 32'(C + 3));

    // Reset mid-WAIT of that transaction
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    expect_all_zero("midreset");
    req = 3'b110; reset = 1'b0;
    @(negedge clock);
    expect_ack("postreset", 3'b010, 10'd60, a0);
    req = '0;
    expect_result("postreset", 0, 2'd1, 4'd0, 4'd6, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
